// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: assembles 3-byte PS/2 mouse packets into buttons + 9-bit deltas.
// Latency: outputs and mouse_data_valid register one cycle after the Y-byte strobe is sampled.
// Backpressure: none; one byte per cycle accepted, consumer must sample on mouse_data_valid.
//
// Ports:
//   CLOCK_50, reset (sync, active-high)
//   ps2_received_data[7:0], ps2_received_data_en : byte stream from the PS/2 controller
//   left/right/middle_button                     : buttons of the last accepted packet
//   mouse_delta_x/y[8:0]                         : {sign, byte} deltas (Y positive = up)
//   mouse_data_valid                             : one-cycle pulse per emitted packet
//   sync_error                                   : one-cycle pulse per dropped byte/timeout/discarded packet
module ps2_mouse_packet_decoder #(
  parameter int TIMEOUT_CYCLES = 500_000,
  parameter bit DROP_OVERFLOW  = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_en,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic [8:0] mouse_delta_x,
  output logic [8:0] mouse_delta_y,
  output logic       mouse_data_valid,
  output logic       sync_error
);

  localparam int GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    WAIT_X   = 2'd1,
    WAIT_Y   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Header fields kept individually; bit3 is only a framing marker.
  logic [2:0]       r_hdr_btn;
  logic             r_hdr_sx;
  logic             r_hdr_sy;
  logic             r_hdr_ovx;
  logic             r_hdr_ovy;
  logic [7:0]       r_x;
  logic             r_first_seen;
  logic [GAP_W-1:0] r_gap;

  logic             w_hdr_ld;
  logic             w_x_ld;
  logic             w_pkt_done;
  logic             w_bad_hdr;
  logic             w_timeout;
  logic             w_expired;
  logic             w_init_resp;
  logic             w_ovf;
  logic             w_emit;
  logic             w_drop;
  logic [8:0]       w_dx;
  logic [8:0]       w_dy;

  assign w_expired   = (r_gap == GAP_MAX);
  // ACK / self-test responses only appear before the first good packet.
  assign w_init_resp = !r_first_seen &&
                       ((ps2_received_data == 8'hFA) || (ps2_received_data == 8'hAA));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= WAIT_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hdr_ld     = 1'b0;
    w_x_ld       = 1'b0;
    w_pkt_done   = 1'b0;
    w_bad_hdr    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      WAIT_HDR: begin
        if (ps2_received_data_en && !w_init_resp) begin
          if (ps2_received_data[3]) begin
            w_hdr_ld     = 1'b1;
            w_next_state = WAIT_X;
          end else begin
            w_bad_hdr = 1'b1;
          end
        end
      end
      WAIT_X: begin
        // A byte arriving on the expiry cycle still wins over the timeout.
        if (ps2_received_data_en) begin
          w_x_ld       = 1'b1;
          w_next_state = WAIT_Y;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = WAIT_HDR;
        end
      end
      WAIT_Y: begin
        if (ps2_received_data_en) begin
          w_pkt_done   = 1'b1;
          w_next_state = WAIT_HDR;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = WAIT_HDR;
        end
      end
      default: w_next_state = WAIT_HDR;
    endcase
  end

  // Packet evaluation; an overflowed axis saturates toward its sign.
  assign w_ovf  = r_hdr_ovx || r_hdr_ovy;
  assign w_emit = w_pkt_done && !(w_ovf && DROP_OVERFLOW);
  assign w_drop = w_pkt_done && w_ovf && DROP_OVERFLOW;
  assign w_dx   = r_hdr_ovx ? (r_hdr_sx ? 9'h101 : 9'h0FF) : {r_hdr_sx, r_x};
  assign w_dy   = r_hdr_ovy ? (r_hdr_sy ? 9'h101 : 9'h0FF) : {r_hdr_sy, ps2_received_data};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hdr_btn        <= 3'b000;
      r_hdr_sx         <= 1'b0;
      r_hdr_sy         <= 1'b0;
      r_hdr_ovx        <= 1'b0;
      r_hdr_ovy        <= 1'b0;
      r_x              <= 8'h00;
      r_first_seen     <= 1'b0;
      left_button      <= 1'b0;
      right_button     <= 1'b0;
      middle_button    <= 1'b0;
      mouse_delta_x    <= 9'h000;
      mouse_delta_y    <= 9'h000;
      mouse_data_valid <= 1'b0;
      sync_error       <= 1'b0;
    end else begin
      mouse_data_valid <= w_emit;
      sync_error       <= w_bad_hdr || w_timeout || w_drop;
      if (w_hdr_ld) begin
        r_hdr_btn <= ps2_received_data[2:0];
        r_hdr_sx  <= ps2_received_data[4];
        r_hdr_sy  <= ps2_received_data[5];
        r_hdr_ovx <= ps2_received_data[6];
        r_hdr_ovy <= ps2_received_data[7];
      end
      if (w_x_ld) begin
        r_x <= ps2_received_data;
      end
      if (w_emit) begin
        left_button   <= r_hdr_btn[0];
        right_button  <= r_hdr_btn[1];
        middle_button <= r_hdr_btn[2];
        mouse_delta_x <= w_dx;
        mouse_delta_y <= w_dy;
        r_first_seen  <= 1'b1;
      end
    end
  end

  // Inter-byte gap: cleared by any strobe or while idle, saturating otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (reset || ps2_received_data_en || (r_state == WAIT_HDR)) begin
      r_gap <= '0;
    end else if (!w_expired) begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Bench for ps2_mouse_packet_decoder: two instances (overflow dropped / saturated)
// share one stimulus stream; a packet-level reference model predicts every cycle.
module tb_ps2_mouse_packet_decoder;

  localparam int TMO = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_received_data = 8'h00;
  logic       ps2_received_data_en = 1'b0;

  logic       l_d [2];
  logic       r_d [2];
  logic       m_d [2];
  logic [8:0] dx_d [2];
  logic [8:0] dy_d [2];
  logic       vld_d [2];
  logic       err_d [2];

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(TMO), .DROP_OVERFLOW(1'b0)) u_dut_sat (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .ps2_received_data(ps2_received_data), .ps2_received_data_en(ps2_received_data_en),
    .left_button(l_d[0]), .right_button(r_d[0]), .middle_button(m_d[0]),
    .mouse_delta_x(dx_d[0]), .mouse_delta_y(dy_d[0]),
    .mouse_data_valid(vld_d[0]), .sync_error(err_d[0])
  );

  ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(TMO), .DROP_OVERFLOW(1'b1)) u_dut_drop (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .ps2_received_data(ps2_received_data), .ps2_received_data_en(ps2_received_data_en),
    .left_button(l_d[1]), .right_button(r_d[1]), .middle_button(m_d[1]),
    .mouse_delta_x(dx_d[1]), .mouse_delta_y(dy_d[1]),
    .mouse_data_valid(vld_d[1]), .sync_error(err_d[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: index 0 saturates overflow, index 1 drops it.
  logic [7:0] m_pkt [2][3];
  int         m_cnt [2];
  int         m_idle [2];
  bit         m_seen [2];
  logic [2:0] e_btn [2];
  logic [8:0] e_dx [2];
  logic [8:0] e_dy [2];
  logic       e_vld [2];
  logic       e_err [2];

  function automatic logic [8:0] axis(input logic sign, input logic ovf, input logic [7:0] mag);
    if (!ovf) return {sign, mag};
    return sign ? 9'h101 : 9'h0FF;
  endfunction

  task automatic model_step(input int m, input bit rst, input bit en, input logic [7:0] b);
    logic [7:0] h;
    e_vld[m] = 1'b0;
    e_err[m] = 1'b0;
    if (rst) begin
      m_cnt[m] = 0; m_idle[m] = 0; m_seen[m] = 1'b0;
      e_btn[m] = 3'b000; e_dx[m] = 9'h000; e_dy[m] = 9'h000;
    end else if (m_cnt[m] == 0) begin
      if (en) begin
        if (!m_seen[m] && (b == 8'hFA || b == 8'hAA)) begin
          // init response, silently ignored
        end else if (b[3]) begin
          m_pkt[m][0] = b; m_cnt[m] = 1; m_idle[m] = 0;
        end else begin
          e_err[m] = 1'b1;
        end
      end
    end else if (en) begin
      m_pkt[m][m_cnt[m]] = b;
      m_cnt[m]++;
      m_idle[m] = 0;
      if (m_cnt[m] == 3) begin
        m_cnt[m] = 0;
        h = m_pkt[m][0];
        if ((h[6] || h[7]) && m == 1) begin
          e_err[m] = 1'b1;
        end else begin
          e_btn[m]  = {h[2], h[1], h[0]};
          e_dx[m]   = axis(h[4], h[6], m_pkt[m][1]);
          e_dy[m]   = axis(h[5], h[7], m_pkt[m][2]);
          e_vld[m]  = 1'b1;
          m_seen[m] = 1'b1;
        end
      end
    end else begin
      // Partial packet abandoned on the TMO-th consecutive idle cycle.
      m_idle[m]++;
      if (m_idle[m] >= TMO) begin
        e_err[m] = 1'b1; m_cnt[m] = 0; m_idle[m] = 0;
      end
    end
  endtask

  task automatic step(input bit en, input logic [7:0] b, input bit rst);
    reset = rst;
    ps2_received_data_en = en;
    ps2_received_data = b;
    @(posedge CLOCK_50);
    model_step(0, rst, en, b);
    model_step(1, rst, en, b);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("vld%0d", m), 32'(vld_d[m]), 32'(e_vld[m]));
      check_eq($sformatf("err%0d", m), 32'(err_d[m]), 32'(e_err[m]));
      check_eq($sformatf("btn%0d", m), 32'({m_d[m], r_d[m], l_d[m]}), 32'(e_btn[m]));
      check_eq($sformatf("dx%0d", m), 32'(dx_d[m]), 32'(e_dx[m]));
      check_eq($sformatf("dy%0d", m), 32'(dy_d[m]), 32'(e_dy[m]));
    end
    reset = 1'b0;
    ps2_received_data_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    int g;
    int r;
    logic [7:0] hdr;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_eq("rst_dx", 32'(dx_d[1]), 32'h000);
    check_eq("rst_vld", 32'(vld_d[1]), 32'h0);

    // Basic packet with negative Y.
    send(8'h29); send(8'h05); send(8'hFB);
    check_eq("p1_vld", 32'(vld_d[1]), 32'h1);
    check_eq("p1_dx", 32'(dx_d[1]), 32'h005);
    check_eq("p1_dy", 32'(dy_d[1]), 32'h1FB);
    check_eq("p1_btn", 32'({m_d[1], r_d[1], l_d[1]}), 32'h1);
    idle(2);

    // Init-response filtering after reset.
    step(1'b0, 8'h00, 1'b1);
    send(8'hFA);
    check_eq("fa_err", 32'(err_d[1]), 32'h0);
    send(8'hAA);
    check_eq("aa_err", 32'(err_d[1]), 32'h0);
    send(8'h00);
    check_eq("00_err", 32'(err_d[1]), 32'h1);
    send(8'h0A); send(8'h00); send(8'h00);
    check_eq("p2_right", 32'(r_d[1]), 32'h1);
    check_eq("p2_vld", 32'(vld_d[1]), 32'h1);

    // Timeout after header + X.
    send(8'h08); send(8'h03);
    idle(TMO - 1);
    check_eq("tmo_early", 32'(err_d[1]), 32'h0);
    idle(1);
    check_eq("tmo_err", 32'(err_d[1]), 32'h1);
    send(8'h09); send(8'h01); send(8'h01);
    check_eq("p3_left", 32'(l_d[1]), 32'h1);
    check_eq("p3_dx", 32'(dx_d[1]), 32'h001);

    // Byte arriving on the expiry cycle is accepted.
    send(8'h08); send(8'h07);
    idle(TMO - 1);
    send(8'h02);
    check_eq("late_vld", 32'(vld_d[1]), 32'h1);

    // X overflow.
    send(8'h48); send(8'h10); send(8'h10);
    check_eq("ovf_drop_err", 32'(err_d[1]), 32'h1);
    check_eq("ovf_drop_dx", 32'(dx_d[1]), 32'h007);
    check_eq("ovf_sat_dx", 32'(dx_d[0]), 32'h0FF);
    check_eq("ovf_sat_vld", 32'(vld_d[0]), 32'h1);

    // Back-to-back packets.
    send(8'h18); send(8'h11); send(8'h22);
    send(8'h28); send(8'h33); send(8'h44);
    check_eq("b2b_dy", 32'(dy_d[1]), 32'h144);

    // Reset mid-packet, then a fresh packet.
    send(8'h09); send(8'h55);
    step(1'b0, 8'h00, 1'b1);
    check_eq("mid_rst_dx", 32'(dx_d[1]), 32'h000);
    send(8'h08); send(8'h06); send(8'h07);
    check_eq("post_rst_dx", 32'(dx_d[1]), 32'h006);

    // Randomized packet stream with junk, init bytes, gaps around the timeout, resets.
    for (int p = 0; p < 400; p++) begin
      for (int k = 0; k < 3; k++) begin
        g = ($urandom % 20 == 0) ? int'($urandom_range(TMO + 2, TMO - 2)) : int'($urandom_range(3, 0));
        idle(g);
        if ($urandom % 250 == 0) step(1'b0, 8'h00, 1'b1);
        if (k == 0) begin
          r = int'($urandom % 16);
          if (r == 0)      hdr = 8'($urandom);
          else if (r == 1) hdr = 8'hFA;
          else if (r == 2) hdr = 8'hAA;
          else begin
            hdr = (8'($urandom) & 8'h37) | 8'h08;
            if ($urandom % 8 == 0) hdr = hdr | 8'h40;
            if ($urandom % 8 == 0) hdr = hdr | 8'h80;
          end
          send(hdr);
        end else begin
          send(8'($urandom));
        end
      end
    end
    idle(TMO + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
